// File: rtl/clk_div_monitor_if.sv
// ---------------------------------------------------------------------------
// clk_div_monitor_if
//
// Bundles the slow-clock input, the flag-clear request and every status /
// measurement output of clk_div_monitor. Clock and reset stay plain ports on
// the module itself.
//
// Signals:
//   SlowIn      divided clock, asynchronous to the board clock
//   Clear       clears the sticky flags and the glitch counter
//   RiseStb     one-cycle strobe on each synchronised rising edge
//   FallStb     one-cycle strobe on each synchronised falling edge
//   HighCnt     last measured high half-period (board clock cycles)
//   LowCnt      last measured low half-period (board clock cycles)
//   PeriodCnt   LowCnt + HighCnt, updated on each rising edge
//   Valid       PeriodCnt holds a complete measurement
//   Locked      half-periods are tracking the expected divide value
//   LossFlag    sticky: slow clock stopped toggling
//   GlitchFlag  sticky: a half-period went out of tolerance while locked
//   ErrCnt      number of glitches, saturating at 255
//
// Modports:
//   master  consumer/stimulus side (drives SlowIn, Clear; reads status)
//   slave   monitor side (reads SlowIn, Clear; drives status)
// ---------------------------------------------------------------------------
interface clk_div_monitor_if #(
    parameter int CNT_W = 16
);
    logic             SlowIn;
    logic             Clear;
    logic             RiseStb;
    logic             FallStb;
    logic [CNT_W-1:0] HighCnt;
    logic [CNT_W-1:0] LowCnt;
    logic [CNT_W:0]   PeriodCnt;
    logic             Valid;
    logic             Locked;
    logic             LossFlag;
    logic             GlitchFlag;
    logic [7:0]       ErrCnt;

    modport master (
        output SlowIn,
        output Clear,
        input  RiseStb,
        input  FallStb,
        input  HighCnt,
        input  LowCnt,
        input  PeriodCnt,
        input  Valid,
        input  Locked,
        input  LossFlag,
        input  GlitchFlag,
        input  ErrCnt
    );

    modport slave (
        input  SlowIn,
        input  Clear,
        output RiseStb,
        output FallStb,
        output HighCnt,
        output LowCnt,
        output PeriodCnt,
        output Valid,
        output Locked,
        output LossFlag,
        output GlitchFlag,
        output ErrCnt
    );
endinterface

// File: rtl/clk_div_monitor.sv
// ---------------------------------------------------------------------------
// clk_div_monitor
//
// Board-clock receiver for the divided clock produced by the clock divider.
// The slow clock is synchronised into the Clk domain, its edges are turned
// into one-cycle strobes, and the high, low and full periods are measured in
// Clk cycles. Each half-period is compared against the expected divide value
// to drive a small lock FSM (IDLE / ACQ / TRACK / LOST) that reports lock,
// loss-of-clock and glitch status for logic that consumes slow-domain data.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth (>= 2)
//   EXP_HALF     expected half-period in Clk cycles
//   TOL          accepted deviation of a half-period from EXP_HALF
//   LOCK_N       consecutive good half-periods needed to lock
//   TIMEOUT      Clk cycles without an edge that declare the clock lost
//                (must be below 2^CNT_W - 1)
//   CNT_W        counter / measurement width
//
// Ports:
//   Clk   board clock
//   Rst   synchronous, active-high reset (every register returns to 0/IDLE)
//   mon   clk_div_monitor_if.slave: SlowIn, Clear in; strobes, counts,
//         Valid, Locked, LossFlag, GlitchFlag, ErrCnt out (all registered)
// ---------------------------------------------------------------------------
module clk_div_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int EXP_HALF    = 10,
    parameter int TOL         = 1,
    parameter int LOCK_N      = 4,
    parameter int TIMEOUT     = 64,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    clk_div_monitor_if.slave mon
);

    localparam int GOOD_W = $clog2(LOCK_N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2,
        LOST  = 2'd3
    } state_t;

    // Saturating increment of the half-period counter.
    function automatic logic [CNT_W-1:0] satIncCnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Saturating increment of the glitch counter.
    function automatic logic [7:0] satIncErr(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    // |m - EXP_HALF| <= TOL, evaluated two bits wider than the count so the
    // subtraction can neither wrap nor lose its sign.
    function automatic logic withinTol(input logic [CNT_W-1:0] m);
        logic signed [CNT_W+1:0] diff;
        diff = $signed({2'b00, m}) - $signed((CNT_W+2)'(EXP_HALF));
        if (diff[CNT_W+1]) begin
            diff = -diff;
        end
        return diff <= $signed((CNT_W+2)'(TOL));
    endfunction

    // Synchroniser and edge detection
    logic [SYNC_STAGES-1:0] slowSync;
    logic                   slowPrev;
    logic                   slowNow;
    logic                   edgeEvt;

    // Half-period measurement
    logic [CNT_W-1:0]       halfCnt;
    logic                   measGood;
    logic                   capture;

    // Registered outputs
    logic                   riseQ;
    logic                   fallQ;
    logic [CNT_W-1:0]       highQ;
    logic [CNT_W-1:0]       lowQ;
    logic [CNT_W:0]         periodQ;
    logic                   validQ;
    logic                   lockedQ;
    logic                   lossQ;
    logic                   glitchQ;
    logic [7:0]             errQ;

    // FSM state and next-state values
    state_t                 state;
    state_t                 stateNext;
    logic [GOOD_W-1:0]      goodCnt;
    logic [GOOD_W-1:0]      goodCntNext;
    logic                   haveHighQ;
    logic                   haveHighNext;
    logic                   validNext;
    logic                   lockedNext;
    logic                   lossNext;
    logic                   glitchNext;
    logic [7:0]             errNext;
    logic [7:0]             errBase;

    assign slowNow  = slowSync[SYNC_STAGES-1];
    assign edgeEvt  = slowNow ^ slowPrev;
    // halfCnt still holds the length of the interval the edge just closed.
    assign measGood = withinTol(halfCnt);

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and flag logic
    // -----------------------------------------------------------------------
    always_comb begin
        stateNext    = state;
        goodCntNext  = goodCnt;
        haveHighNext = haveHighQ;
        validNext    = validQ;
        lockedNext   = lockedQ;
        lossNext     = lossQ;
        glitchNext   = glitchQ;
        errBase      = errQ;
        capture      = 1'b0;

        // Clear is applied first so that a set in the same cycle wins.
        if (mon.Clear) begin
            lossNext   = 1'b0;
            glitchNext = 1'b0;
            errBase    = 8'd0;
        end
        errNext = errBase;

        if (edgeEvt) begin
            case (state)
                IDLE, LOST: begin
                    // The interval ending here started at an unknown point,
                    // so it is not measured.
                    stateNext    = ACQ;
                    goodCntNext  = '0;
                    haveHighNext = 1'b0;
                end
                ACQ: begin
                    capture = 1'b1;
                    if (measGood) begin
                        goodCntNext = goodCnt + GOOD_W'(1);
                        if (goodCnt == GOOD_W'(LOCK_N - 1)) begin
                            stateNext  = TRACK;
                            lockedNext = 1'b1;
                        end
                    end else begin
                        goodCntNext = '0;
                    end
                end
                TRACK: begin
                    capture = 1'b1;
                    if (!measGood) begin
                        stateNext   = ACQ;
                        goodCntNext = '0;
                        lockedNext  = 1'b0;
                        glitchNext  = 1'b1;
                        errNext     = satIncErr(errBase);
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase

            if (capture) begin
                if (slowNow) begin
                    // Rising edge closes a low half and completes a period.
                    validNext = validQ | haveHighQ;
                end else begin
                    haveHighNext = 1'b1;
                end
            end
        end else if ((state != LOST) && (halfCnt == CNT_W'(TIMEOUT))) begin
            stateNext    = LOST;
            lockedNext   = 1'b0;
            lossNext     = 1'b1;
            validNext    = 1'b0;
            haveHighNext = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Synchroniser, strobes, counter, measurements and flags
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            slowSync  <= '0;
            slowPrev  <= 1'b0;
            halfCnt   <= '0;
            riseQ     <= 1'b0;
            fallQ     <= 1'b0;
            highQ     <= '0;
            lowQ      <= '0;
            periodQ   <= '0;
            goodCnt   <= '0;
            haveHighQ <= 1'b0;
            validQ    <= 1'b0;
            lockedQ   <= 1'b0;
            lossQ     <= 1'b0;
            glitchQ   <= 1'b0;
            errQ      <= 8'd0;
        end else begin
            slowSync  <= {slowSync[SYNC_STAGES-2:0], mon.SlowIn};
            slowPrev  <= slowNow;
            riseQ     <= slowNow & ~slowPrev;
            fallQ     <= ~slowNow & slowPrev;
            halfCnt   <= edgeEvt ? CNT_W'(1) : satIncCnt(halfCnt);
            goodCnt   <= goodCntNext;
            haveHighQ <= haveHighNext;
            validQ    <= validNext;
            lockedQ   <= lockedNext;
            lossQ     <= lossNext;
            glitchQ   <= glitchNext;
            errQ      <= errNext;

            if (capture) begin
                if (slowNow) begin
                    lowQ    <= halfCnt;
                    periodQ <= {1'b0, halfCnt} + {1'b0, highQ};
                end else begin
                    highQ   <= halfCnt;
                end
            end
        end
    end

    assign mon.RiseStb    = riseQ;
    assign mon.FallStb    = fallQ;
    assign mon.HighCnt    = highQ;
    assign mon.LowCnt     = lowQ;
    assign mon.PeriodCnt  = periodQ;
    assign mon.Valid      = validQ;
    assign mon.Locked     = lockedQ;
    assign mon.LossFlag   = lossQ;
    assign mon.GlitchFlag = glitchQ;
    assign mon.ErrCnt     = errQ;

endmodule

// File: tb/tb_clk_div_monitor.sv
// ---------------------------------------------------------------------------
// tb_clk_div_monitor
//
// Drives the divided clock as a sequence of half-periods (directed scenarios
// followed by randomised lengths, holds, clears and resets) and compares the
// monitor outputs every cycle against a behavioural model that works from
// edge timestamps: a slow-clock transition sampled at edge n is seen by the
// monitor at edge n+SYNC_STAGES, and a half-period is the distance between
// two such seen transitions.
// ---------------------------------------------------------------------------
module tb_clk_div_monitor;

    localparam int S       = 2;
    localparam int EXP     = 10;
    localparam int TOLV    = 1;
    localparam int LOCKN   = 4;
    localparam int TMO     = 64;
    localparam int CW      = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk;
    logic rst;
    bit   cmpEn;

    int nChecks;
    int nFails;

    clk_div_monitor_if #(.CNT_W(CW)) bus ();

    clk_div_monitor #(
        .SYNC_STAGES (S),
        .EXP_HALF    (EXP),
        .TOL         (TOLV),
        .LOCK_N      (LOCKN),
        .TIMEOUT     (TMO),
        .CNT_W       (CW)
    ) dut (
        .Clk (clk),
        .Rst (rst),
        .mon (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model. mState: 0 idle, 1 acquiring, 2 tracking, 3 lost.
    int     mState;
    int     mGood;
    int     mErr;
    int     mHigh;
    int     mLow;
    int     mPeriod;
    bit     mLocked;
    bit     mLoss;
    bit     mGlitch;
    bit     mValid;
    bit     mHaveHigh;
    bit     mRise;
    bit     mFall;
    longint edgeNo;
    longint anchor;     // edge index at which the interval count was zero
    bit     hist [0:S]; // hist[0] = SlowIn sampled at the previous edge

    initial begin
        edgeNo = 0;
        anchor = 0;
        for (int i = 0; i <= S; i++) hist[i] = 1'b0;
    end

    always @(posedge clk) begin
        longint el;
        int     meas;
        bit     ev;
        bit     rise;
        bit     good;
        edgeNo = edgeNo + 1;
        if (rst) begin
            mState = 0; mGood = 0; mErr = 0; mHigh = 0; mLow = 0; mPeriod = 0;
            mLocked = 0; mLoss = 0; mGlitch = 0; mValid = 0; mHaveHigh = 0;
            mRise = 0; mFall = 0;
            anchor = edgeNo;
            for (int i = 0; i <= S; i++) hist[i] = 1'b0;
        end else begin
            ev   = (hist[S-1] != hist[S]);
            rise = ev && hist[S-1];
            el   = edgeNo - 1 - anchor;
            meas = (el > CNT_MAX) ? CNT_MAX : int'(el);
            good = (meas >= EXP - TOLV) && (meas <= EXP + TOLV);
            mRise = rise;
            mFall = ev && !rise;
            if (bus.Clear) begin
                mLoss = 0; mGlitch = 0; mErr = 0;
            end
            if (ev) begin
                anchor = edgeNo - 1;
                if (mState == 0 || mState == 3) begin
                    mState = 1; mGood = 0; mHaveHigh = 0;
                end else begin
                    if (rise) begin
                        mLow = meas;
                        mPeriod = meas + mHigh;
                        if (mHaveHigh) mValid = 1;
                    end else begin
                        mHigh = meas;
                        mHaveHigh = 1;
                    end
                    if (mState == 1) begin
                        if (good) begin
                            mGood = mGood + 1;
                            if (mGood == LOCKN) begin
                                mState = 2; mLocked = 1;
                            end
                        end else begin
                            mGood = 0;
                        end
                    end else if (!good) begin
                        mGlitch = 1;
                        mErr = (mErr < 255) ? mErr + 1 : 255;
                        mGood = 0; mState = 1; mLocked = 0;
                    end
                end
            end else if (mState != 3 && meas == TMO) begin
                mState = 3; mLoss = 1; mLocked = 0; mValid = 0; mHaveHigh = 0;
            end
            for (int i = S; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = bus.SlowIn;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareAll();
        chk("RiseStb",    32'(bus.RiseStb),    32'(mRise));
        chk("FallStb",    32'(bus.FallStb),    32'(mFall));
        chk("HighCnt",    32'(bus.HighCnt),    32'(mHigh));
        chk("LowCnt",     32'(bus.LowCnt),     32'(mLow));
        chk("PeriodCnt",  32'(bus.PeriodCnt),  32'(mPeriod));
        chk("Valid",      32'(bus.Valid),      32'(mValid));
        chk("Locked",     32'(bus.Locked),     32'(mLocked));
        chk("LossFlag",   32'(bus.LossFlag),   32'(mLoss));
        chk("GlitchFlag", 32'(bus.GlitchFlag), 32'(mGlitch));
        chk("ErrCnt",     32'(bus.ErrCnt),     32'(mErr));
    endtask

    task automatic tick();
        @(negedge clk);
        if (cmpEn) compareAll();
    endtask

    task automatic toggleWait(input int len);
        bus.SlowIn = ~bus.SlowIn;
        repeat (len) tick();
    endtask

    // From TRACK: one 7-cycle half, then four good halves to relock.
    task automatic glitchRelock();
        toggleWait(7);
        toggleWait(10);
        repeat (4) toggleWait(10);
    endtask

    initial begin
        nChecks    = 0;
        nFails     = 0;
        cmpEn      = 1'b1;
        rst        = 1'b1;
        bus.SlowIn = 1'b0;
        bus.Clear  = 1'b0;
        repeat (3) tick();
        chk("rst_Locked",    32'(bus.Locked),    0);
        chk("rst_Valid",     32'(bus.Valid),     0);
        chk("rst_ErrCnt",    32'(bus.ErrCnt),    0);
        chk("rst_HighCnt",   32'(bus.HighCnt),   0);
        chk("rst_PeriodCnt", 32'(bus.PeriodCnt), 0);
        chk("rst_LossFlag",  32'(bus.LossFlag),  0);
        rst = 1'b0;

        // Nominal 10/10 toggling: lock on the fifth seen edge.
        repeat (4) toggleWait(10);
        bus.SlowIn = ~bus.SlowIn;
        tick(); tick();
        chk("lock_before_edge", 32'(bus.Locked), 0);
        tick();
        chk("lock_at_edge", 32'(bus.Locked), 1);
        chk("rise_strobe_on", 32'(bus.RiseStb), 1);
        tick();
        chk("rise_strobe_off", 32'(bus.RiseStb), 0);
        repeat (6) tick();
        repeat (7) toggleWait(10);
        chk("nom_HighCnt",   32'(bus.HighCnt),   10);
        chk("nom_LowCnt",    32'(bus.LowCnt),    10);
        chk("nom_PeriodCnt", 32'(bus.PeriodCnt), 20);
        chk("nom_Valid",     32'(bus.Valid),     1);
        chk("nom_Locked",    32'(bus.Locked),    1);
        chk("nom_flags",     32'({bus.LossFlag, bus.GlitchFlag}), 0);
        chk("model_period",  32'(mPeriod),       20);

        // Jittered 9/11 halves stay locked.
        repeat (4) begin
            toggleWait(9);
            toggleWait(11);
        end
        chk("jit_Locked",    32'(bus.Locked),    1);
        chk("jit_HighCnt",   32'(bus.HighCnt),   9);
        chk("jit_LowCnt",    32'(bus.LowCnt),    11);
        chk("jit_PeriodCnt", 32'(bus.PeriodCnt), 20);
        chk("jit_Glitch",    32'(bus.GlitchFlag), 0);

        // A 7-cycle half while locked is a glitch; four good halves relock.
        toggleWait(7);
        toggleWait(10);
        chk("gl_Glitch", 32'(bus.GlitchFlag), 1);
        chk("gl_ErrCnt", 32'(bus.ErrCnt),     1);
        chk("gl_Locked", 32'(bus.Locked),     0);
        chk("model_err", 32'(mErr),           1);
        repeat (3) toggleWait(10);
        chk("relock_early", 32'(bus.Locked), 0);
        toggleWait(10);
        chk("relock", 32'(bus.Locked), 1);

        // Stopped clock -> loss; Clear; resume and relock.
        repeat (70) tick();
        chk("loss_Flag",   32'(bus.LossFlag), 1);
        chk("loss_Locked", 32'(bus.Locked),   0);
        chk("loss_Valid",  32'(bus.Valid),    0);
        bus.Clear = 1'b1;
        tick();
        bus.Clear = 1'b0;
        tick();
        chk("loss_cleared", 32'(bus.LossFlag), 0);
        repeat (2) toggleWait(10);
        chk("resume_Valid_low", 32'(bus.Valid), 0);
        repeat (10) toggleWait(10);
        chk("resume_Valid",  32'(bus.Valid),  1);
        chk("resume_Locked", 32'(bus.Locked), 1);

        // Five glitches, then Clear coinciding with the sixth.
        repeat (5) glitchRelock();
        chk("err5", 32'(bus.ErrCnt), 5);
        toggleWait(7);
        bus.SlowIn = ~bus.SlowIn;
        tick(); tick();
        bus.Clear = 1'b1;
        tick();
        bus.Clear = 1'b0;
        chk("clr_set_Glitch", 32'(bus.GlitchFlag), 1);
        chk("clr_set_ErrCnt", 32'(bus.ErrCnt),     1);
        repeat (7) tick();
        repeat (4) toggleWait(10);

        // Glitch counter saturation.
        bus.Clear = 1'b1;
        tick();
        bus.Clear = 1'b0;
        repeat (9) tick();
        repeat (256) glitchRelock();
        chk("err_sat",     32'(bus.ErrCnt),     255);
        chk("sat_Glitch",  32'(bus.GlitchFlag), 1);

        // Reset while locked.
        chk("pre_rst_Locked", 32'(bus.Locked), 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_Locked", 32'(bus.Locked),    0);
        chk("mid_rst_Glitch", 32'(bus.GlitchFlag), 0);
        chk("mid_rst_ErrCnt", 32'(bus.ErrCnt),    0);
        chk("mid_rst_HighCnt", 32'(bus.HighCnt),  0);
        chk("mid_rst_Valid",  32'(bus.Valid),     0);
        rst = 1'b0;
        repeat (12) toggleWait(10);
        chk("post_rst_Glitch", 32'(bus.GlitchFlag), 0);
        chk("post_rst_Locked", 32'(bus.Locked),     1);

        // Randomised half-periods, holds, clears and resets.
        for (int k = 0; k < 400; k++) begin
            int r;
            int len;
            int clrAt;
            r = int'($urandom_range(99));
            if (r < 3) begin
                repeat (int'($urandom_range(80, 60))) tick();
            end else if (r < 4) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                if (r < 10)      len = int'($urandom_range(8, 1));
                else if (r < 15) len = int'($urandom_range(16, 12));
                else             len = int'($urandom_range(11, 9));
                if (r >= 95) clrAt = int'($urandom_range(len - 1));
                else         clrAt = -1;
                bus.SlowIn = ~bus.SlowIn;
                for (int j = 0; j < len; j++) begin
                    bus.Clear = (j == clrAt);
                    tick();
                end
                bus.Clear = 1'b0;
            end
        end
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
